uart_tx_arbiter: RTL

//  Round-robin arbiter sharing one fast_8N1_UART_TX among N_REQ byte-stream requesters.

---
 rtl/uart_tx_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter that shares one 8N1 UART transmitter among N_REQ
//   byte-stream requesters. A requester that presents a byte with last=0
//   locks the transmitter until it presents a byte with last=1. Each granted
//   byte is handed to the transmitter with a one-cycle load pulse. Completion
//   is tracked through the transmitter's load-ok (idle) flag. A watchdog
//   recovers from two situations: a transmitter that never accepts a byte,
//   and a locked owner that stops requesting.
//
// Ports
//   i_sys_clk     system clock, all logic on rising edge
//   i_rst_n       asynchronous active-low reset
//   i_en          allow new grants (an in-flight byte always completes)
//   i_req         per-requester byte valid, held until acknowledged
//   i_req_data    byte of requester i at [i*BYTE_W +: BYTE_W]
//   i_req_last    byte is the last one of its packet
//   o_req_ack     one-cycle pulse: byte of requester i taken
//   o_grant_id    index of the current / most recent owner
//   o_busy        high while a byte is being handed over or transmitted
//   o_err         one-cycle pulse on any watchdog expiry
//   o_tx_load     one-cycle load pulse to the transmitter
//   o_tx_data     byte to the transmitter, held until the next grant
//   i_tx_load_ok  transmitter idle flag
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int BYTE_W      = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     i_sys_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*BYTE_W-1:0]  i_req_data,
    input  logic [N_REQ-1:0]         i_req_last,
    output logic [N_REQ-1:0]         o_req_ack,
    output logic [$clog2(N_REQ)-1:0] o_grant_id,
    output logic                     o_busy,
    output logic                     o_err,
    output logic                     o_tx_load,
    output logic [BYTE_W-1:0]        o_tx_data,
    input  logic                     i_tx_load_ok
);

    localparam int GNT_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [GNT_W-1:0] PTR_INIT = GNT_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ARB         = 2'b00,
        WAIT_ACCEPT = 2'b01,
        WAIT_DONE   = 2'b10
    } state_t;

    state_t             r_state,    w_state_nxt;
    logic               r_lock,     w_lock_nxt;
    logic [GNT_W-1:0]   r_rr_ptr,   w_rr_ptr_nxt;
    logic [WD_W-1:0]    r_wd,       w_wd_nxt;
    logic [GNT_W-1:0]   r_grant_id, w_grant_id_nxt;
    logic [BYTE_W-1:0]  r_tx_data,  w_tx_data_nxt;
    logic               r_tx_load,  w_tx_load_nxt;
    logic [N_REQ-1:0]   r_req_ack,  w_req_ack_nxt;
    logic               r_err,      w_err_nxt;
    logic               r_busy,     w_busy_nxt;

    logic [N_REQ-1:0]   w_owner_mask;
    logic               w_owner_req;
    logic [N_REQ-1:0]   w_cand;
    logic               w_found;
    logic [GNT_W-1:0]   w_win;
    logic [BYTE_W-1:0]  w_win_data;

    // Candidate set: while a packet is locked only the owner may win.
    always_comb begin
        w_owner_mask = ONE_HOT0 << r_grant_id;
        w_owner_req  = |(i_req & w_owner_mask);
        if (r_lock) begin
            w_cand = i_req & w_owner_mask;
        end else begin
            w_cand = i_req;
        end
    end

    // Round-robin search starting just after the last winner, wrapping modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_win   = (!w_found && w_cand[GNT_W'((int'(r_rr_ptr) + i + 32'sd1) % N_REQ)])
                      ? GNT_W'((int'(r_rr_ptr) + i + 32'sd1) % N_REQ) : w_win;
            w_found = w_found | w_cand[GNT_W'((int'(r_rr_ptr) + i + 32'sd1) % N_REQ)];
        end
        w_win_data = i_req_data[int'(w_win)*BYTE_W +: BYTE_W];
    end

    // Next-state and next-output logic for the arbitration FSM and watchdog.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_nxt     = r_lock;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_wd_nxt       = r_wd;
        w_grant_id_nxt = r_grant_id;
        w_tx_data_nxt  = r_tx_data;
        w_tx_load_nxt  = 1'b0;
        w_req_ack_nxt  = '0;
        w_err_nxt      = 1'b0;
        case (r_state)
            ARB: begin
                if (i_en && i_tx_load_ok && w_found) begin
                    w_state_nxt    = WAIT_ACCEPT;
                    w_tx_load_nxt  = 1'b1;
                    w_tx_data_nxt  = w_win_data;
                    w_req_ack_nxt  = ONE_HOT0 << w_win;
                    w_grant_id_nxt = w_win;
                    w_rr_ptr_nxt   = w_win;
                    w_lock_nxt     = ~i_req_last[w_win];
                    w_wd_nxt       = '0;
                end else if (r_lock && !w_owner_req) begin
                    // Locked owner has gone quiet: release the lock on expiry.
                    // A grant cannot coincide, since the only candidate is idle.
                    if (r_wd == WD_LAST) begin
                        w_lock_nxt = 1'b0;
                        w_err_nxt  = 1'b1;
                        w_wd_nxt   = '0;
                    end else begin
                        w_wd_nxt = r_wd + 1'b1;
                    end
                end else begin
                    w_wd_nxt = r_wd;
                end
            end
            WAIT_ACCEPT: begin
                if (!i_tx_load_ok) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_wd == WD_LAST) begin
                    // Transmitter never took the byte: drop it, do not retry.
                    w_err_nxt   = 1'b1;
                    w_lock_nxt  = 1'b0;
                    w_wd_nxt    = '0;
                    w_state_nxt = ARB;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end
            WAIT_DONE: begin
                // Frame time is bounded by the transmitter itself, so no watchdog here.
                if (i_tx_load_ok) begin
                    w_state_nxt = ARB;
                    w_wd_nxt    = '0;
                end else begin
                    w_state_nxt = WAIT_DONE;
                end
            end
            default: begin
                w_state_nxt = ARB;
                w_lock_nxt  = 1'b0;
                w_wd_nxt    = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ARB);
    end

    // State, watchdog and registered outputs.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ARB;
            r_lock     <= 1'b0;
            r_rr_ptr   <= PTR_INIT;
            r_wd       <= '0;
            r_grant_id <= '0;
            r_tx_data  <= '0;
            r_tx_load  <= 1'b0;
            r_req_ack  <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock     <= w_lock_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_wd       <= w_wd_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_load  <= w_tx_load_nxt;
            r_req_ack  <= w_req_ack_nxt;
            r_err      <= w_err_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign o_req_ack  = r_req_ack;
    assign o_grant_id = r_grant_id;
    assign o_busy     = r_busy;
    assign o_err      = r_err;
    assign o_tx_load  = r_tx_load;
    assign o_tx_data  = r_tx_data;

endmodule
